// File: rtl/sprite_fetcher.sv
// Per-scanline sprite evaluation: scans the 64 OAM entries for sprites on the next line, keeps the
// first eight in OAM order, fetches both pattern planes from CHR and emits one packed record per slot.
module sprite_fetcher #(
  parameter int MAXSPR = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [7:0]  line,
  input  logic [7:0]  ctrl,
  output logic [7:0]  oam_addr,
  input  logic [7:0]  oam_data,
  output logic        chr_req,
  output logic [12:0] chr_addr,
  input  logic        chr_ack,
  input  logic [7:0]  chr_data,
  output logic        spr_wr,
  output logic [2:0]  spr_idx,
  output logic [31:0] spr_data,
  output logic [3:0]  spr_count,
  output logic        spr0_in,
  output logic        overflow,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] MaxCount = 4'(MAXSPR);

  typedef enum logic [3:0] {
    IDLE, RDY, CHK, RDT, RDA, RDX, FLO, FHI, WR, FIN
  } state_e;

  state_e      state_q;
  logic [5:0]  n_q;
  logic [3:0]  dist_q;
  logic [7:0]  tile_q;
  logic [7:0]  attr_q;
  logic [7:0]  x_q;
  logic [7:0]  plane0_q;
  logic [7:0]  oamAddr_q;
  logic        chrReq_q;
  logic [12:0] chrAddr_q;
  logic        sprWr_q;
  logic [2:0]  sprIdx_q;
  logic [31:0] sprData_q;
  logic [3:0]  sprCount_q;
  logic        spr0In_q;
  logic        overflow_q;
  logic        done_q;

  logic [7:0]  dist_d;
  logic        hit_d;
  logic [3:0]  row_d;
  logic [12:0] chrAddr_d;
  logic [31:0] record_d;
  logic        unusedCtrl;

  function automatic logic [7:0] revByte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

  // Y compare uses 8-bit wrap on purpose, so entries just above the line can still hit via wrap.
  assign dist_d = line - oam_data;
  assign hit_d  = ctrl[5] ? (dist_d < 8'd16) : (dist_d < 8'd8);

  // Attribute byte is on oam_data during RDX, so the vertical flip is resolved straight from it.
  assign row_d = oam_data[7] ? ((ctrl[5] ? 4'd15 : 4'd7) - dist_q) : dist_q;
  assign chrAddr_d = ctrl[5] ? {tile_q[0], tile_q[7:1], row_d[3], 1'b0, row_d[2:0]}
                             : {ctrl[3], tile_q, 1'b0, row_d[2:0]};

  assign record_d = {attr_q[6] ? revByte(chr_data) : chr_data,
                     attr_q,
                     attr_q[6] ? revByte(plane0_q) : plane0_q,
                     x_q};

  assign unusedCtrl = ^{ctrl[7:6], ctrl[4], ctrl[2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      dist_q     <= '0;
      tile_q     <= '0;
      attr_q     <= '0;
      x_q        <= '0;
      plane0_q   <= '0;
      oamAddr_q  <= '0;
      chrReq_q   <= 1'b0;
      chrAddr_q  <= '0;
      sprWr_q    <= 1'b0;
      sprIdx_q   <= '0;
      sprData_q  <= '0;
      sprCount_q <= '0;
      spr0In_q   <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sprWr_q <= 1'b0;
      done_q  <= 1'b0;
      // An outstanding CHR request is always retired by its ack, even one orphaned by a restart.
      if (chr_ack && chrReq_q) chrReq_q <= 1'b0;

      if (line_start) begin
        state_q    <= RDY;
        n_q        <= '0;
        oamAddr_q  <= '0;
        sprCount_q <= '0;
        overflow_q <= 1'b0;
        spr0In_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: state_q <= IDLE;
          RDY: begin
            // Hold here until an orphaned fetch from an aborted pass has been acked.
            if (!chrReq_q) state_q <= CHK;
          end
          CHK: begin
            dist_q <= dist_d[3:0];
            if (!hit_d) begin
              if (n_q == 6'd63) begin
                state_q <= FIN;
                done_q  <= 1'b1;
              end else begin
                n_q       <= n_q + 6'd1;
                oamAddr_q <= {n_q + 6'd1, 2'b00};
                state_q   <= RDY;
              end
            end else if (sprCount_q == MaxCount) begin
              overflow_q <= 1'b1;
              state_q    <= FIN;
              done_q     <= 1'b1;
            end else begin
              oamAddr_q <= {n_q, 2'b01};
              state_q   <= RDT;
            end
          end
          RDT: begin
            oamAddr_q <= {n_q, 2'b10};
            state_q   <= RDA;
          end
          RDA: begin
            tile_q    <= oam_data;
            oamAddr_q <= {n_q, 2'b11};
            state_q   <= RDX;
          end
          RDX: begin
            attr_q    <= oam_data;
            chrAddr_q <= chrAddr_d;
            chrReq_q  <= 1'b1;
            state_q   <= FLO;
          end
          FLO: begin
            x_q <= oam_data;
            if (chr_ack) begin
              plane0_q  <= chr_data;
              chrAddr_q <= {chrAddr_q[12:4], 1'b1, chrAddr_q[2:0]};
              chrReq_q  <= 1'b1;
              state_q   <= FHI;
            end
          end
          FHI: begin
            if (chr_ack) begin
              sprWr_q    <= 1'b1;
              sprIdx_q   <= sprCount_q[2:0];
              sprData_q  <= record_d;
              sprCount_q <= sprCount_q + 4'd1;
              if (n_q == 6'd0) spr0In_q <= 1'b1;
              state_q    <= WR;
            end
          end
          WR: begin
            if (n_q == 6'd63) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              n_q       <= n_q + 6'd1;
              oamAddr_q <= {n_q + 6'd1, 2'b00};
              state_q   <= RDY;
            end
          end
          FIN: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign oam_addr  = oamAddr_q;
  assign chr_req   = chrReq_q & ~rst;
  assign chr_addr  = chrAddr_q;
  assign spr_wr    = sprWr_q;
  assign spr_idx   = sprIdx_q;
  assign spr_data  = sprData_q;
  assign spr_count = sprCount_q;
  assign spr0_in   = spr0In_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_sprite_fetcher.sv
// Bench for sprite_fetcher: OAM/CHR memory models, directed cases and randomized passes checked
// against a scanline-level reference model of sprite selection and record packing.
module tb_sprite_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic [7:0]  line = 8'd0;
  logic [7:0]  ctrl = 8'd0;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data = 8'd0;
  logic        chr_req;
  logic [12:0] chr_addr;
  logic        chr_ack = 1'b0;
  logic [7:0]  chr_data = 8'd0;
  logic        spr_wr;
  logic [2:0]  spr_idx;
  logic [31:0] spr_data;
  logic [3:0]  spr_count;
  logic        spr0_in;
  logic        overflow;
  logic        busy;
  logic        done;

  int tests = 0;
  int failures = 0;
  int doneCycles;
  int ackDelay = 0;
  int chrWait = 0;

  logic [7:0]  oamMem [256];
  logic [7:0]  chrMem [8192];
  logic [12:0] addrLog [$];
  logic [34:0] recQ [$];

  logic [34:0] expRec [$];
  logic [12:0] expAddr [$];
  logic [3:0]  expCount;
  logic        expOvf;
  logic        expSpr0;

  sprite_fetcher #(.MAXSPR(8)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .line(line), .ctrl(ctrl),
    .oam_addr(oam_addr), .oam_data(oam_data),
    .chr_req(chr_req), .chr_addr(chr_addr), .chr_ack(chr_ack), .chr_data(chr_data),
    .spr_wr(spr_wr), .spr_idx(spr_idx), .spr_data(spr_data), .spr_count(spr_count),
    .spr0_in(spr0_in), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) oam_data <= oamMem[oam_addr];

  // CHR responder: acks each request ackDelay cycles after it is seen, logging the address served.
  always @(posedge clk) begin
    if (rst) begin
      chr_ack <= 1'b0;
      chrWait <= 0;
    end else if (chr_ack) begin
      chr_ack <= 1'b0;
      chrWait <= 0;
    end else if (chr_req) begin
      if (chrWait >= ackDelay) begin
        chr_ack  <= 1'b1;
        chr_data <= chrMem[chr_addr];
        addrLog.push_back(chr_addr);
      end else begin
        chrWait <= chrWait + 1;
      end
    end else begin
      chrWait <= 0;
    end
  end

  always @(negedge clk) if (!rst && spr_wr) recQ.push_back({spr_idx, spr_data});

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] recAt(input int i);
    if (i < recQ.size()) return 64'(recQ[i]);
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] addrAt(input int i);
    if (i < addrLog.size()) return 64'(addrLog[i]);
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  task automatic clearOam();
    for (int i = 0; i < 64; i++) begin
      oamMem[4*i]   = 8'hF0;
      oamMem[4*i+1] = 8'h00;
      oamMem[4*i+2] = 8'h00;
      oamMem[4*i+3] = 8'h00;
    end
  endtask

  task automatic setSprite(input int i, input logic [7:0] y, input logic [7:0] t,
                           input logic [7:0] a, input logic [7:0] x);
    oamMem[4*i] = y; oamMem[4*i+1] = t; oamMem[4*i+2] = a; oamMem[4*i+3] = x;
  endtask

  // Reference: walk OAM, pick the first eight sprites whose row offset falls inside the sprite height.
  task automatic runModel(input logic [7:0] ln, input logic [7:0] ct);
    int h, d, r, a, cnt;
    logic [7:0] tile, attr, x, p0, p1, t0, t1;
    expRec.delete(); expAddr.delete();
    expOvf = 1'b0; expSpr0 = 1'b0; cnt = 0;
    h = ct[5] ? 16 : 8;
    for (int i = 0; i < 64; i++) begin
      d = (int'(ln) - int'(oamMem[4*i])) & 255;
      if (d < h) begin
        if (cnt == 8) begin
          expOvf = 1'b1;
          break;
        end
        tile = oamMem[4*i+1]; attr = oamMem[4*i+2]; x = oamMem[4*i+3];
        r = attr[7] ? (h - 1 - d) : d;
        if (h == 8) a = (ct[3] ? 4096 : 0) + int'(tile) * 16 + r;
        else a = (int'(tile) % 2) * 4096 + (int'(tile) / 2) * 32 + (r / 8) * 16 + (r % 8);
        p0 = chrMem[a]; p1 = chrMem[a + 8];
        if (attr[6]) begin
          for (int k = 0; k < 8; k++) begin t0[k] = p0[7-k]; t1[k] = p1[7-k]; end
          p0 = t0; p1 = t1;
        end
        expRec.push_back({3'(cnt), p1, attr, p0, x});
        expAddr.push_back(13'(a));
        expAddr.push_back(13'(a + 8));
        if (i == 0) expSpr0 = 1'b1;
        cnt++;
      end
    end
    expCount = 4'(cnt);
  endtask

  task automatic applyStimulus(input logic [7:0] ln, input logic [7:0] ct, input string tag);
    line = ln; ctrl = ct;
    recQ.delete(); addrLog.delete();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    doneCycles = 1;
    while (done !== 1'b1 && doneCycles < 3000) begin
      @(negedge clk);
      doneCycles++;
    end
    checkOutput({tag, ".doneSeen"}, 64'(done), 64'd1);
  endtask

  task automatic checkPass(input string tag);
    checkOutput({tag, ".count"}, 64'(spr_count), 64'(expCount));
    checkOutput({tag, ".overflow"}, 64'(overflow), 64'(expOvf));
    checkOutput({tag, ".spr0in"}, 64'(spr0_in), 64'(expSpr0));
    checkOutput({tag, ".nrec"}, 64'(recQ.size()), 64'(expRec.size()));
    for (int i = 0; i < expRec.size(); i++)
      checkOutput({tag, ".rec"}, recAt(i), 64'(expRec[i]));
    for (int i = 0; i < expAddr.size(); i++)
      checkOutput({tag, ".chrAddr"}, addrAt(i), 64'(expAddr[i]));
  endtask

  initial begin
    logic [7:0] lnR, ctR;
    int spread, guard;

    for (int i = 0; i < 8192; i++) chrMem[i] = 8'($urandom);
    clearOam();

    // Reset state
    @(negedge clk); @(negedge clk);
    checkOutput("reset.oamAddr", 64'(oam_addr), 64'd0);
    checkOutput("reset.chrAddr", 64'(chr_addr), 64'd0);
    checkOutput("reset.chrReq", 64'(chr_req), 64'd0);
    checkOutput("reset.sprData", 64'({spr_wr, spr_idx, spr_data}), 64'd0);
    checkOutput("reset.status", 64'({spr_count, spr0_in, overflow, busy, done}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // All sprites off-line: full 64-entry scan, nothing fetched
    runModel(8'd10, 8'h08);
    applyStimulus(8'd10, 8'h08, "empty");
    checkOutput("empty.doneLatency", 64'(doneCycles), 64'd129);
    checkPass("empty");
    @(negedge clk);
    checkOutput("empty.busyAfter", 64'(busy), 64'd0);

    // Single sprite 0, 8x8 from pattern table 1
    setSprite(0, 8'd9, 8'h12, 8'h01, 8'h40);
    chrMem[13'h1121] = 8'h81; chrMem[13'h1129] = 8'hF0;
    runModel(8'd10, 8'h08);
    applyStimulus(8'd10, 8'h08, "s0");
    checkOutput("s0.addrLo", addrAt(0), 64'h1121);
    checkOutput("s0.addrHi", addrAt(1), 64'h1129);
    checkOutput("s0.record", recAt(0), 64'hF0018140);
    checkPass("s0");

    // Horizontal flip reverses both plane bytes
    setSprite(0, 8'd9, 8'h12, 8'h41, 8'h40);
    runModel(8'd10, 8'h08);
    applyStimulus(8'd10, 8'h08, "hflip");
    checkOutput("hflip.record", recAt(0), 64'h0F418140);
    checkPass("hflip");

    // Vertical flip on row 0 selects the bottom row
    setSprite(0, 8'd9, 8'h12, 8'h81, 8'h40);
    runModel(8'd9, 8'h08);
    applyStimulus(8'd9, 8'h08, "vflip");
    checkOutput("vflip.addrLo", addrAt(0), 64'h1127);
    checkOutput("vflip.addrHi", addrAt(1), 64'h112F);
    checkPass("vflip");

    // 8x16 sprite, bottom tile
    setSprite(0, 8'd0, 8'h13, 8'h00, 8'h22);
    runModel(8'd12, 8'h20);
    applyStimulus(8'd12, 8'h20, "tall");
    checkOutput("tall.addrLo", addrAt(0), 64'h1134);
    checkOutput("tall.addrHi", addrAt(1), 64'h113C);
    checkPass("tall");

    // Ten sprites in range: first eight kept in OAM order, overflow flagged
    clearOam();
    for (int k = 0; k < 10; k++)
      setSprite(3 + k, 8'd50 - 8'(k % 6), 8'(k * 3 + 1), 8'(k * 16), 8'(3 + k));
    ackDelay = 2;
    runModel(8'd50, 8'h08);
    applyStimulus(8'd50, 8'h08, "ovf");
    checkOutput("ovf.count", 64'(spr_count), 64'd8);
    checkOutput("ovf.flag", 64'(overflow), 64'd1);
    checkOutput("ovf.spr0in", 64'(spr0_in), 64'd0);
    for (int i = 0; i < 8; i++)
      checkOutput("ovf.slotOrder", recAt(i) & 64'h7_0000_00FF, (64'(i) << 32) | 64'(3 + i));
    checkPass("ovf");

    // Restart during the plane1 fetch of the second sprite, with a slow ack
    clearOam();
    setSprite(0, 8'd38, 8'h05, 8'h00, 8'h10);
    setSprite(5, 8'd35, 8'h09, 8'h40, 8'h20);
    runModel(8'd40, 8'h00);
    ackDelay = 5;
    line = 8'd40; ctrl = 8'h00;
    recQ.delete(); addrLog.delete();
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    guard = 0;
    while (addrLog.size() < 3 && guard < 500) begin @(negedge clk); guard++; end
    checkOutput("abort.reachFhi", 64'(addrLog.size()), 64'd3);
    @(negedge clk); @(negedge clk);
    checkOutput("abort.reqBefore", 64'(chr_req), 64'd1);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    recQ.delete();
    checkOutput("abort.reqHeld", 64'(chr_req), 64'd1);
    checkOutput("abort.countCleared", 64'({spr_count, spr0_in}), 64'd0);
    guard = 0;
    while (chr_req === 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    checkOutput("abort.reqDropped", 64'(chr_req), 64'd0);
    addrLog.delete();
    doneCycles = 0;
    while (done !== 1'b1 && doneCycles < 3000) begin @(negedge clk); doneCycles++; end
    checkOutput("abort.doneSeen", 64'(done), 64'd1);
    checkPass("abort");

    // Reset in the middle of a CHR fetch
    ackDelay = 10;
    line = 8'd40; ctrl = 8'h00;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    guard = 0;
    while (chr_req !== 1'b1 && guard < 500) begin @(negedge clk); guard++; end
    checkOutput("rstFetch.reqUp", 64'(chr_req), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstFetch.reqDrop", 64'(chr_req), 64'd0);
    @(negedge clk);
    checkOutput("rstFetch.state", 64'({busy, spr_count, chr_req}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Randomized passes against the reference model
    for (int t = 0; t < 8; t++) begin
      lnR = 8'($urandom_range(0, 239));
      ctR = 8'($urandom);
      spread = $urandom_range(12, 90);
      for (int i = 0; i < 64; i++)
        setSprite(i, lnR - 8'($urandom_range(0, spread)), 8'($urandom), 8'($urandom), 8'($urandom));
      ackDelay = $urandom_range(0, 3);
      runModel(lnR, ctR);
      applyStimulus(lnR, ctR, "rnd");
      checkPass("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
